// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: issue-side operand fetch, pending-write scoreboard and a one-entry operand stage.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to matching sources instead of stalling.
module regfile_access_ctrl #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [4:0]       op_rd,
    output logic             op_rd_we,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             rf_write_enabled,
    output logic [4:0]       rf_write_location,
    output logic [WIDTH-1:0] rf_write_data,
    output logic [4:0]       rf_read1_location,
    input  logic [WIDTH-1:0] rf_read1_out,
    output logic [4:0]       rf_read2_location,
    input  logic [WIDTH-1:0] rf_read2_out,
    output logic [15:0]      stall_count
);

    localparam logic [5:0] SIZE_LIM = 6'(SIZE);

    // Location 0 and locations at or beyond SIZE are hardwired zero and never tracked.
    function automatic logic is_real(input logic [4:0] loc);
        return (loc != 5'd0) && ({1'b0, loc} < SIZE_LIM);
    endfunction

    function automatic logic pending_of(input logic [SIZE-1:0] vec, input logic [4:0] loc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (loc == 5'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    logic [SIZE-1:0]  pending;
    logic [SIZE-1:0]  pending_next;
    logic             rs1_real, rs2_real, rd_real, wb_real;
    logic             rs1_pend, rs2_pend, rd_pend;
    logic             wb_hit1, wb_hit2;
    logic             src_hazard, hazard, accept;
    logic [WIDTH-1:0] op_a_next, op_b_next;

    assign rf_read1_location = issue_rs1;
    assign rf_read2_location = issue_rs2;
    assign rf_write_enabled  = wb_valid && wb_real;
    assign rf_write_location = wb_rd;
    assign rf_write_data     = wb_data;

    always_comb begin
        rs1_real = is_real(issue_rs1);
        rs2_real = is_real(issue_rs2);
        rd_real  = is_real(issue_rd);
        wb_real  = is_real(wb_rd);
        rs1_pend = pending_of(pending, issue_rs1);
        rs2_pend = pending_of(pending, issue_rs2);
        rd_pend  = pending_of(pending, issue_rd);
        wb_hit1  = wb_valid && wb_real && (wb_rd == issue_rs1);
        wb_hit2  = wb_valid && wb_real && (wb_rd == issue_rs2);
`ifdef REGFILE_BYPASS_EN
        src_hazard = (rs1_pend && !wb_hit1) || (rs2_pend && !wb_hit2);
        op_a_next  = !rs1_real ? '0 : (wb_hit1 ? wb_data : rf_read1_out);
        op_b_next  = !rs2_real ? '0 : (wb_hit2 ? wb_data : rf_read2_out);
`else
        // The array still returns the old value during its write cycle, so a matching source waits one cycle.
        src_hazard = rs1_pend || rs2_pend || wb_hit1 || wb_hit2;
        op_a_next  = rs1_real ? rf_read1_out : '0;
        op_b_next  = rs2_real ? rf_read2_out : '0;
`endif
        hazard = src_hazard || (issue_rd_we && rd_pend);
    end

    // Handshake: a transfer happens on a posedge where valid && ready; the operand stage holds
    // its entry stable until op_ready, and issue_ready never depends on issue_valid.
    assign issue_ready = (!op_valid || op_ready) && !hazard;
    assign accept      = issue_valid && issue_ready;

    always_comb begin
        pending_next = pending;
        for (int i = 0; i < SIZE; i++) begin
            if (wb_valid && wb_real && (wb_rd == 5'(i))) pending_next[i] = 1'b0;
        end
        // Set after clear so a same-cycle issue to the same destination keeps it pending.
        for (int i = 0; i < SIZE; i++) begin
            if (accept && issue_rd_we && rd_real && (issue_rd == 5'(i))) pending_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_rd       <= 5'd0;
            op_rd_we    <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                op_valid <= 1'b1;
                op_a     <= op_a_next;
                op_b     <= op_b_next;
                op_rd    <= issue_rd;
                op_rd_we <= issue_rd_we;
            end else if (op_valid && op_ready) begin
                op_valid <= 1'b0;
            end
            if (issue_valid && !issue_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register array; a second SIZE=4 instance covers range limits.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_rd_we, op_ready, wb_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic [31:0] wb_data;

    logic        issue_ready, op_valid, op_rd_we, rf_write_enabled;
    logic [31:0] op_a, op_b, rf_write_data, rf_read1_out, rf_read2_out;
    logic [4:0]  op_rd, rf_write_location, rf_read1_location, rf_read2_location;
    logic [15:0] stall_count;

    logic        s_issue_ready, s_op_valid, s_op_rd_we, s_rf_write_enabled;
    logic [31:0] s_op_a, s_op_b, s_rf_write_data;
    logic [4:0]  s_op_rd, s_rf_write_location, s_rf_read1_location, s_rf_read2_location;
    logic [15:0] s_stall_count;
    logic [31:0] s_read_out;

    logic [31:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
    localparam int EXTRA_STALL = 0;
`else
    localparam int EXTRA_STALL = 1;
`endif

    // Clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (rf_write_enabled) begin
            mem[rf_write_location] <= rf_write_data;
        end
    end

    assign rf_read1_out = mem[rf_read1_location];
    assign rf_read2_out = mem[rf_read2_location];
    assign s_read_out   = 32'hA5A5_A5A5;

    regfile_access_ctrl #(.WIDTH(32), .SIZE(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_rd_we(op_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_write_enabled(rf_write_enabled), .rf_write_location(rf_write_location),
        .rf_write_data(rf_write_data),
        .rf_read1_location(rf_read1_location), .rf_read1_out(rf_read1_out),
        .rf_read2_location(rf_read2_location), .rf_read2_out(rf_read2_out),
        .stall_count(stall_count)
    );

    regfile_access_ctrl #(.WIDTH(32), .SIZE(4)) dut_small (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(s_issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .op_valid(s_op_valid), .op_ready(op_ready), .op_a(s_op_a), .op_b(s_op_b),
        .op_rd(s_op_rd), .op_rd_we(s_op_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_write_enabled(s_rf_write_enabled), .rf_write_location(s_rf_write_location),
        .rf_write_data(s_rf_write_data),
        .rf_read1_location(s_rf_read1_location), .rf_read1_out(s_read_out),
        .rf_read2_location(s_rf_read2_location), .rf_read2_out(s_read_out),
        .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we);
        issue_valid = 1'b1;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_rd_we = we;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        op_ready    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Writeback releases the stalled source; bypass accepts the same cycle, otherwise one cycle later.
    task automatic resolve_with_wb(input logic [4:0] rd, input logic [31:0] data, input string tag);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        #1;
`ifdef REGFILE_BYPASS_EN
        check({tag, "_ready_bypass"}, 32'(issue_ready), 32'd1);
        tick();
        wb_valid    = 1'b0;
        issue_valid = 1'b0;
`else
        check({tag, "_ready_wb_cycle"}, 32'(issue_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check({tag, "_ready_after_wb"}, 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
`endif
        check({tag, "_op_a"}, op_a, data);
    endtask

    initial begin
        issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_rd_we = 1'b0;
        wb_rd = 5'd0; wb_data = 32'd0;
        do_reset();

        // Reset state and the zero-location instruction
        #1;
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_ready", 32'(issue_ready), 32'd1);
        drive_issue(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        issue_valid = 1'b0;
        check("zero_op_valid", 32'(op_valid), 32'd1);
        check("zero_op_a", op_a, 32'd0);
        check("zero_op_b", op_b, 32'd0);
        check("zero_op_rd_we", 32'(op_rd_we), 32'd1);
        check("zero_stall", 32'(stall_count), 32'd0);
        #1;
        check("zero_no_pending", 32'(issue_ready), 32'd1);

        // RAW hazard on r5
        drive_issue(5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        check("raw_first_op_a", op_a, 32'hC0DE_0001);
        check("raw_first_op_b", op_b, 32'hC0DE_0002);
        check("raw_first_op_rd", 32'(op_rd), 32'd5);
        drive_issue(5'd5, 5'd0, 5'd6, 1'b0);
        #1;
        check("raw_stall_ready", 32'(issue_ready), 32'd0);
        tick(); tick(); tick();
        check("raw_stall_count", 32'(stall_count), 32'd3);
        check("raw_wb_we", 32'(rf_write_enabled), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; #1;
        check("raw_wb_we_on", 32'(rf_write_enabled), 32'd1);
        resolve_with_wb(5'd5, 32'hDEADBEEF, "raw");
        check("raw_stall_final", 32'(stall_count), 32'(3 + EXTRA_STALL));

        // Backpressure and back-to-back accept
        tick();
        op_ready = 1'b0;
        drive_issue(5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive_issue(5'd3, 5'd4, 5'd0, 1'b0);
        #1;
        check("bp_ready_low", 32'(issue_ready), 32'd0);
        tick(); tick();
        check("bp_op_valid", 32'(op_valid), 32'd1);
        check("bp_op_a_stable", op_a, 32'hC0DE_0001);
        check("bp_op_b_stable", op_b, 32'hC0DE_0002);
        check("bp_stall", 32'(stall_count), 32'(5 + EXTRA_STALL));
        op_ready = 1'b1;
        #1;
        check("bp_ready_high", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        check("b2b_op_valid", 32'(op_valid), 32'd1);
        check("b2b_op_a", op_a, 32'hC0DE_0003);
        check("b2b_op_b", op_b, 32'hC0DE_0004);
        tick();
        check("drain_op_valid", 32'(op_valid), 32'd0);

        // Same-cycle set and clear on r7: set wins
        drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1111_0007;
        #1;
        check("setclr_ready", 32'(issue_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        drive_issue(5'd7, 5'd0, 5'd0, 1'b0);
        #1;
        check("setclr_pending", 32'(issue_ready), 32'd0);
        tick(); tick();
        check("setclr_still_pending", 32'(issue_ready), 32'd0);
        resolve_with_wb(5'd7, 32'h7777_0007, "setclr");
        check("setclr_stall", 32'(stall_count), 32'(7 + 2 * EXTRA_STALL));

        // Unimplemented locations
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1;
        #1;
        check("wb_r0_we", 32'(rf_write_enabled), 32'd0);
        check("wb_r0_we_small", 32'(s_rf_write_enabled), 32'd0);
        wb_rd = 5'd9; wb_data = 32'h0000_0999;
        #1;
        check("wb_r9_we", 32'(rf_write_enabled), 32'd1);
        check("wb_r9_we_small", 32'(s_rf_write_enabled), 32'd0);
        tick();
        wb_valid = 1'b0;
        drive_issue(5'd9, 5'd3, 5'd0, 1'b0);
        tick();
        issue_valid = 1'b0;
        check("oor_op_a_small", s_op_a, 32'd0);
        check("oor_op_b_small", s_op_b, 32'hA5A5_A5A5);
        check("oor_op_a", op_a, 32'h0000_0999);
        check("oor_op_b", op_b, 32'hC0DE_0003);

        // Stall counter saturation, then reset mid-stall
        do_reset();
        drive_issue(5'd0, 5'd0, 5'd10, 1'b1);
        tick();
        drive_issue(5'd10, 5'd0, 5'd0, 1'b0);
        repeat (65534) tick();
        check("sat_fffe", 32'(stall_count), 32'h0000_FFFE);
        tick();
        check("sat_ffff", 32'(stall_count), 32'h0000_FFFF);
        repeat (5000) tick();
        check("sat_hold", 32'(stall_count), 32'h0000_FFFF);
        check("sat_ready", 32'(issue_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("midrst_stall", 32'(stall_count), 32'd0);
        check("midrst_op_valid", 32'(op_valid), 32'd0);
        check("midrst_pending", 32'(issue_ready), 32'd1);
        reset = 1'b0;
        tick();
        issue_valid = 1'b0;
        check("midrst_accept", 32'(op_valid), 32'd1);
        check("midrst_op_a", op_a, 32'hC0DE_000A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator side of the register-file port set. Drives write enable, write location, write data and both read locations into the data-register array, then consumes the two read outputs.
- Sits between decode (issue), writeback and execute (operand).
- Keeps a pending-write scoreboard per register and stalls issue on RAW/WAW hazards.
- Registers fetched operands into a one-entry valid/ready output stage.

Parameters:
- WIDTH, 32, data width; must match the register array.
- SIZE, 32, number of architectural registers; locations >= SIZE are unimplemented.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction accepted this cycle when high together with issue_valid
- issue_rs1  in  5  source 1 location
- issue_rs2  in  5  source 2 location
- issue_rd  in  5  destination location
- issue_rd_we  in  1  instruction will write issue_rd
- op_valid  out  1  operand stage holds a valid entry
- op_ready  in  1  execute consumes the entry
- op_a  out  WIDTH  source 1 value
- op_b  out  WIDTH  source 2 value
- op_rd  out  5  destination passed through
- op_rd_we  out  1  write flag passed through
- wb_valid  in  1  writeback result present; always accepted
- wb_rd  in  5  writeback location
- wb_data  in  WIDTH  writeback value
- rf_write_enabled  out  1  to array write_enabled
- rf_write_location  out  5  to array write_location
- rf_write_data  out  WIDTH  to array write_data
- rf_read1_location  out  5  to array read1_location
- rf_read1_out  in  WIDTH  from array read1_out
- rf_read2_location  out  5  from issue_rs2, to array read2_location
- rf_read2_out  in  WIDTH  from array read2_out
- stall_count  out  16  saturating count of stalled issue cycles

Behaviour:
- Reset clears pending[SIZE-1:0], op_valid, op_a, op_b, op_rd, op_rd_we and stall_count to 0. This also applies to reset asserted mid-operation: the in-flight op entry is dropped.
- Location validity: a location is real if it is non-zero and < SIZE.
  - Location 0 and out-of-range locations read as 0, are never written and are never pending.
- Read path:
  - rf_read1_location = issue_rs1 and rf_read2_location = issue_rs2, combinationally.
  - The array outputs are combinational and are captured into op_a/op_b on the accept edge.
- Write path (combinational from the wb_* inputs):
  - rf_write_enabled = wb_valid and wb_rd real.
  - rf_write_location = wb_rd.
  - rf_write_data = wb_data.
  - The array updates on the same posedge.
- Hazard:
  - A hazard exists if pending[issue_rs1], pending[issue_rs2], or (issue_rd_we and pending[issue_rd]).
  - Without the optional feature, a source matching a same-cycle writeback is also a hazard, because the array still returns the old value that cycle.
- issue_ready = (!op_valid or op_ready) and no hazard. The accept edge is issue_valid and issue_ready.
- On accept:
  - op_valid <= 1.
  - op_a/op_b <= read data, forced to 0 for non-real sources.
  - op_rd <= issue_rd; op_rd_we <= issue_rd_we.
  - If issue_rd_we and issue_rd real, then pending[issue_rd] <= 1.
- If op_valid and op_ready and no accept, then op_valid <= 0. Latency is 1 cycle from accept to op_valid.
- wb_valid with wb_rd real clears pending[wb_rd].
  - Same-cycle set (accept) and clear on the same location: set wins.
  - Writeback to a non-pending register is legal: it writes the array and leaves pending unchanged.
- stall_count increments when issue_valid and not issue_ready. It saturates at 16'hFFFF.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wb_valid, wb_rd is real and it equals a source location, that operand takes wb_data instead of the array output.
  - That source is not a hazard, because its pending bit clears the same edge.
  - WAW on rd still stalls.
- Undefined:
  - Such a source is a hazard and stalls one cycle.
  - The next cycle it reads the updated array.

Test Plan:
- Reset, then issue rs1=0, rs2=0, rd=0, rd_we=1 -> op_a=0, op_b=0 one cycle later; pending stays all-zero; no stall.
- Issue rd=5 we=1, then issue rs1=5 -> second instruction stalls (issue_ready=0, stall_count counts). wb_valid rd=5 data=32'hDEADBEEF:
  - With bypass: accepted that cycle with op_a=32'hDEADBEEF.
  - Without bypass: accepted the next cycle with op_a=32'hDEADBEEF.
- op_ready held low with op_valid=1 -> issue_ready=0 and op_a/op_b stable. Raise op_ready with a new issue pending -> back-to-back accept, no bubble.
- Same cycle: issue rd=7 we=1 and wb rd=7 -> pending[7]=1 afterwards; a later issue rs1=7 stalls until a second wb to rd=7.
- wb_valid rd=0 data=32'h1 -> rf_write_enabled=0. SIZE=4 with wb rd=9 -> rf_write_enabled=0; issue rs1=9 -> op_a=0.
- Hold issue_valid against a hazard for 70000 cycles -> stall_count=16'hFFFF. Assert reset mid-stall -> stall_count=0, op_valid=0, pending cleared.
